// File: rtl/sigma_stream.sv
// sigma_stream: streams an NxN single-precision matrix and computes
// sigma = max(SCALE*||A||, OFFSET + sqrt(OFFSET + ||A||)) + err using one shared add/mul/sqrt core.
// Optional build macro SIGMA_STREAM_ABS_EN: clear each element's sign bit so ||A|| is the true infinity norm.
module sigma_stream #(
  parameter int          PRECISION    = 32,
  parameter int          N            = 3,
  parameter logic [31:0] SCALE        = 32'h40400000,
  parameter logic [31:0] OFFSET       = 32'h3F800000,
  parameter int          FLUSH_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PRECISION-1:0] s_data,
  input  logic [PRECISION-1:0] err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PRECISION-1:0] sigma,
  output logic                 busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [3:0] {FLUSH, IDLE, LOAD, ACC, ROWEND, NORM, SQRT, ADD2, ERR, OUT} state_t;

  // Round-to-nearest-even on a 27-bit mantissa (leading one at bit 26) and saturate the exponent.
  function automatic logic [31:0] fp_round(input logic s, input logic signed [10:0] e_in,
                                           input logic [26:0] m);
    logic signed [10:0] e;
    logic [24:0]        r;
    logic               up;
    e  = e_in;
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    if (r[24]) begin
      r = r >> 1;
      e = e + 11'sd1;
    end
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [26:0]        mx, my, mask, m;
    logic [27:0]        sum;
    logic signed [10:0] e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC00000;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      my = {26'd0, 1'b1};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      my   = (my >> d) | {26'd0, |(my & mask)};
    end
    e = $signed({3'b000, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = e + 11'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = mx - my;
      if (m == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 11'sd1;
        end
      end
    end
    return fp_round(x[31], e, m);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        p;
    logic signed [10:0] e;
    logic [26:0]        m;
    logic               s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
          a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h7FC00000;
      return {s, 8'hFF, 23'd0};
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m = {p[47:22], |p[21:0]};
      e = e + 11'sd1;
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return fp_round(s, e, m);
  endfunction

  // Digit-by-digit integer root of the mantissa scaled so the root carries guard/round bits.
  function automatic logic [31:0] fp_sqrt(input logic [31:0] a);
    logic [51:0]        x;
    logic [29:0]        rem, trial;
    logic [25:0]        q;
    logic signed [10:0] e;
    if (a[30:23] == 8'd0) return {a[31], 31'd0};
    if (a[31]) return 32'h7FC00000;
    if (a[30:23] == 8'hFF) return a;
    e = $signed({3'b000, a[30:23]}) - 11'sd127;
    if (e[0]) begin
      x = {1'b1, a[22:0], 28'd0};
      e = e - 11'sd1;
    end else begin
      x = {1'b0, 1'b1, a[22:0], 27'd0};
    end
    rem = 30'd0;
    q   = 26'd0;
    for (int i = 25; i >= 0; i--) begin
      rem   = {rem[27:0], x[2*i +: 2]};
      trial = {2'b00, q, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        q   = {q[24:0], 1'b1};
      end else begin
        q = {q[24:0], 1'b0};
      end
    end
    return fp_round(1'b0, (e >>> 1) + 11'sd127, {q, |rem});
  endfunction

  // Ordered compare on sign/magnitude; +0 and -0 are equal.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return b[31];
    if (a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  state_t                state_q, state_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]         row_q, row_d, col_q, col_d;
  logic                  s_ready_q, s_ready_d, m_valid_q, m_valid_d, busy_q, busy_d;
  logic                  add_vld_q, add_vld_d, mul_vld_q, mul_vld_d, sqrt_vld_q, sqrt_vld_d;
  logic                  mul_got_q, mul_got_d, add2_got_q, add2_got_d;
  logic [PRECISION-1:0]  sigma_q, sigma_d, acc_q, acc_d, max_q, max_d, err_q, err_d;
  logic [PRECISION-1:0]  mul_hold_q, mul_hold_d, add2_q, add2_d;
  logic [PRECISION-1:0]  add_a_q, add_a_d, add_b_q, add_b_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [PRECISION-1:0]  sqrt_a_q, sqrt_a_d;
  logic [PRECISION-1:0]  elem, cand, mres;
  logic                  beat;

  logic [PRECISION-1:0]  add_res_p1, add_res_p2, mul_res_p1, mul_res_p2, mul_res_p3;
  logic [PRECISION-1:0]  sqrt_res_p1, sqrt_res_p2, sqrt_res_p3, sqrt_res_p4;
  logic                  add_vld_p1, add_vld_p2, mul_vld_p1, mul_vld_p2, mul_vld_p3;
  logic                  sqrt_vld_p1, sqrt_vld_p2, sqrt_vld_p3, sqrt_vld_p4;

`ifdef SIGMA_STREAM_ABS_EN
  assign elem = {1'b0, s_data[PRECISION-2:0]};
`else
  assign elem = s_data;
`endif

  assign beat    = s_valid & s_ready_q;
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign sigma   = sigma_q;
  assign busy    = busy_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    m_valid_d   = m_valid_q;
    sigma_d     = sigma_q;
    acc_d       = acc_q;
    max_d       = max_q;
    err_d       = err_q;
    mul_hold_d  = mul_hold_q;
    mul_got_d   = mul_got_q;
    add2_d      = add2_q;
    add2_got_d  = add2_got_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    sqrt_a_d    = sqrt_a_q;
    add_vld_d   = 1'b0;
    mul_vld_d   = 1'b0;
    sqrt_vld_d  = 1'b0;
    cand        = add_vld_p2 ? add_res_p2 : add2_q;
    mres        = mul_vld_p3 ? mul_res_p3 : mul_hold_q;

    // The product may land in any state after issue; keep it until ADD2 consumes it.
    if (mul_vld_p3 && state_q != FLUSH) begin
      mul_hold_d = mul_res_p3;
      mul_got_d  = 1'b1;
    end

    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH_CYCLES)) state_d = IDLE;
        else flush_cnt_d = flush_cnt_q + FW'(1);
      end
      IDLE: begin
        if (beat) begin
          acc_d   = elem;
          err_d   = err;
          row_d   = '0;
          col_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          if (col_q == '0) begin
            acc_d = elem;
            col_d = CW'(1);
          end else begin
            add_a_d   = acc_q;
            add_b_d   = elem;
            add_vld_d = 1'b1;
            state_d   = ACC;
          end
        end
      end
      ACC: begin
        if (add_vld_p2) begin
          acc_d = add_res_p2;
          if (col_q == LAST) begin
            col_d   = '0;
            state_d = ROWEND;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = LOAD;
          end
        end
      end
      ROWEND: begin
        if (row_q == '0 || fp_gt(acc_q, max_q)) max_d = acc_q;
        if (row_q == LAST) begin
          row_d     = '0;
          mul_a_d   = SCALE;
          mul_b_d   = max_d;
          mul_vld_d = 1'b1;
          add_a_d   = OFFSET;
          add_b_d   = max_d;
          add_vld_d = 1'b1;
          mul_got_d = 1'b0;
          state_d   = NORM;
        end else begin
          row_d   = row_q + CW'(1);
          state_d = LOAD;
        end
      end
      NORM: begin
        if (add_vld_p2) begin
          sqrt_a_d   = add_res_p2;
          sqrt_vld_d = 1'b1;
          state_d    = SQRT;
        end
      end
      SQRT: begin
        if (sqrt_vld_p4) begin
          add_a_d    = sqrt_res_p4;
          add_b_d    = OFFSET;
          add_vld_d  = 1'b1;
          add2_got_d = 1'b0;
          state_d    = ADD2;
        end
      end
      ADD2: begin
        if (add_vld_p2) begin
          add2_d     = add_res_p2;
          add2_got_d = 1'b1;
        end
        if ((add_vld_p2 || add2_got_q) && (mul_vld_p3 || mul_got_q)) begin
          add_a_d   = fp_gt(cand, mres) ? cand : mres;
          add_b_d   = err_q;
          add_vld_d = 1'b1;
          state_d   = ERR;
        end
      end
      ERR: begin
        if (add_vld_p2) begin
          sigma_d   = add_res_p2;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (m_ready && m_valid_q) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase

    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b1;
      sigma_q     <= '0;
      add_vld_q   <= 1'b0;
      mul_vld_q   <= 1'b0;
      sqrt_vld_q  <= 1'b0;
      mul_got_q   <= 1'b0;
      add2_got_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      sigma_q     <= sigma_d;
      add_vld_q   <= add_vld_d;
      mul_vld_q   <= mul_vld_d;
      sqrt_vld_q  <= sqrt_vld_d;
      mul_got_q   <= mul_got_d;
      add2_got_q  <= add2_got_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q      <= acc_d;
    max_q      <= max_d;
    err_q      <= err_d;
    mul_hold_q <= mul_hold_d;
    add2_q     <= add2_d;
    add_a_q    <= add_a_d;
    add_b_q    <= add_b_d;
    mul_a_q    <= mul_a_d;
    mul_b_q    <= mul_b_d;
    sqrt_a_q   <= sqrt_a_d;
  end

  // Shared cores: no reset, so stale valids are drained by FLUSH.
  always_ff @(posedge clk) begin
    add_res_p1  <= fp_add(add_a_q, add_b_q);
    add_vld_p1  <= add_vld_q;
    add_res_p2  <= add_res_p1;
    add_vld_p2  <= add_vld_p1;
    mul_res_p1  <= fp_mul(mul_a_q, mul_b_q);
    mul_vld_p1  <= mul_vld_q;
    mul_res_p2  <= mul_res_p1;
    mul_vld_p2  <= mul_vld_p1;
    mul_res_p3  <= mul_res_p2;
    mul_vld_p3  <= mul_vld_p2;
    sqrt_res_p1 <= fp_sqrt(sqrt_a_q);
    sqrt_vld_p1 <= sqrt_vld_q;
    sqrt_res_p2 <= sqrt_res_p1;
    sqrt_vld_p2 <= sqrt_vld_p1;
    sqrt_res_p3 <= sqrt_res_p2;
    sqrt_vld_p3 <= sqrt_vld_p2;
    sqrt_res_p4 <= sqrt_res_p3;
    sqrt_vld_p4 <= sqrt_vld_p3;
  end

endmodule

// File: tb/tb_sigma_stream.sv
// Directed bench for sigma_stream: an N=3 and an N=2 instance share one stimulus port, selected by sel.
module tb_sigma_stream;
  localparam int          FC   = 32;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] HALF = 32'h3F000000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] FOUR = 32'h40800000;
  localparam logic [31:0] NEG2 = 32'hC0000000;

  logic        clk = 1'b0;
  logic        reset_n, s_valid, m_ready, sel;
  logic [31:0] s_data, err_in;
  logic        s_ready3, m_valid3, busy3, s_ready2, m_valid2, busy2;
  logic [31:0] sigma3, sigma2;
  logic        s_ready, m_valid, busy;
  logic [31:0] sigma;
  logic [31:0] mat [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign s_ready = sel ? s_ready2 : s_ready3;
  assign m_valid = sel ? m_valid2 : m_valid3;
  assign busy    = sel ? busy2 : busy3;
  assign sigma   = sel ? sigma2 : sigma3;

  sigma_stream #(.N(3), .FLUSH_CYCLES(FC)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid & ~sel), .s_ready(s_ready3),
    .s_data(s_data), .err(err_in), .m_valid(m_valid3), .m_ready(m_ready & ~sel),
    .sigma(sigma3), .busy(busy3)
  );

  sigma_stream #(.N(2), .FLUSH_CYCLES(FC)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid & sel), .s_ready(s_ready2),
    .s_data(s_data), .err(err_in), .m_valid(m_valid2), .m_ready(m_ready & sel),
    .sigma(sigma2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mat();
    for (int i = 0; i < 16; i++) mat[i] = 32'd0;
  endtask

  task automatic set_identity();
    clear_mat();
    mat[0] = ONE;
    mat[4] = ONE;
    mat[8] = ONE;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [31:0] e);
    int t;
    t       = 0;
    s_valid = 1'b1;
    s_data  = d;
    err_in  = e;
    @(negedge clk);
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_matrix(input int n, input logic [31:0] e, input int maxgap);
    int g;
    for (int i = 0; i < n * n; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      send_beat(mat[i], e);
    end
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp, input int hold);
    int          t;
    logic [31:0] first;
    t = 0;
    while (!m_valid && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd1);
    chk({tag, "_sigma"}, sigma, exp);
    first = sigma;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_sigma"}, sigma, first);
      chk({tag, "_hold_m_valid"}, {31'd0, m_valid}, 32'd1);
      chk({tag, "_hold_s_ready"}, {31'd0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk({tag, "_m_valid_drop"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_s_ready_back"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic mv_seen;
    sel     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = 32'd0;
    err_in  = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready3}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid3}, 32'd0);
    chk("rst_sigma", sigma3, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd1);
    chk("rst_busy_n2", {31'd0, busy2}, 32'd1);
    reset_n = 1'b1;

    n = 0;
    while (!s_ready && n < FC + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("flush_done", {31'd0, s_ready}, 32'd1);

    set_identity();
    send_matrix(3, 32'd0, 0);
    get_result("identity", 32'h40400000, 0);

    clear_mat();
    send_matrix(3, 32'd0, 0);
    get_result("zeros", 32'h40000000, 0);

    clear_mat();
    mat[0] = NEG2;
    send_matrix(3, 32'd0, 0);
`ifdef SIGMA_STREAM_ABS_EN
    get_result("neg_row", 32'h40C00000, 0);
`else
    get_result("neg_row", 32'h40000000, 0);
`endif

    sel = 1'b1;
    for (int i = 0; i < 4; i++) mat[i] = HALF;
    send_matrix(2, ONE, 0);
    get_result("n2_half", 32'h40800000, 0);
    sel = 1'b0;

    // Row sums 3.0, 1.5, 4.0 -> 3*4 = 12 beats 1+sqrt(5); plus err 0.5.
    clear_mat();
    mat[0] = ONE;
    mat[1] = TWO;
    mat[3] = HALF;
    mat[4] = HALF;
    mat[5] = HALF;
    mat[8] = FOUR;
    send_matrix(3, HALF, 3);
    get_result("gapped", 32'h41480000, 5);

    set_identity();
    send_matrix(3, 32'd0, 2);
    get_result("after_gap", 32'h40400000, 0);

    set_identity();
    for (int i = 0; i < 4; i++) send_beat(mat[i], 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n       = 0;
    mv_seen = 1'b0;
    while (!s_ready && n < FC + 20) begin
      if (m_valid) mv_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("flush_len", n, FC + 1);
    chk("flush_m_valid", {31'd0, mv_seen}, 32'd0);
    send_matrix(3, 32'd0, 0);
    get_result("post_reset", 32'h40400000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
